// File: rtl/pacessor_pkg.sv
// rtl/pacessor_pkg.sv - opcodes, FSM states and instruction field widths for pacessor_mc
// Ports: none (package).
package pacessor_pkg;

   localparam int OP_W    = 8;
   localparam int FIELD_W = 8;

   localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
   localparam logic [OP_W-1:0] OP_ADD  = 8'h01;
   localparam logic [OP_W-1:0] OP_SUB  = 8'h02;
   localparam logic [OP_W-1:0] OP_AND  = 8'h03;
   localparam logic [OP_W-1:0] OP_OR   = 8'h04;
   localparam logic [OP_W-1:0] OP_XOR  = 8'h05;
   localparam logic [OP_W-1:0] OP_NOT  = 8'h06;
   localparam logic [OP_W-1:0] OP_SHL  = 8'h07;
   localparam logic [OP_W-1:0] OP_SHR  = 8'h08;
   localparam logic [OP_W-1:0] OP_EQ   = 8'h09;
   localparam logic [OP_W-1:0] OP_MUL  = 8'h0a;
   localparam logic [OP_W-1:0] OP_LOAD = 8'h10;
   localparam logic [OP_W-1:0] OP_DISP = 8'h1f;
   localparam logic [OP_W-1:0] OP_JMP  = 8'h20;
   localparam logic [OP_W-1:0] OP_BEQ  = 8'h21;
   localparam logic [OP_W-1:0] OP_HALT = 8'h3f;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_OUT   = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/pacessor_regfile.sv
// rtl/pacessor_regfile.sv - NREG x DATA_W register file, two async read ports, one sync write port
// Ports: clk; rst_n async active-low, clears every entry; ra_idx/ra_data and rb_idx/rb_data
//        combinational reads; we/wd_idx/wd_data write on the rising edge of clk.
module pacessor_regfile #(
   parameter int DATA_W = 8,
   parameter int NREG   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [$clog2(NREG)-1:0] ra_idx,
   input  logic [$clog2(NREG)-1:0] rb_idx,
   output logic [DATA_W-1:0]       ra_data,
   output logic [DATA_W-1:0]       rb_data,
   input  logic                    we,
   input  logic [$clog2(NREG)-1:0] wd_idx,
   input  logic [DATA_W-1:0]       wd_data
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[wd_idx] = wd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads see the pre-write value, so an instruction whose dest equals a source reads the old value.
   assign ra_data = regs_q[ra_idx];
   assign rb_data = regs_q[rb_idx];

endmodule

// File: rtl/pacessor_mc.sv
// rtl/pacessor_mc.sv - multi-cycle CPU core: fetch over req/ack, execute, output via valid/ready
// Ports: clk; rst_master_n async active-low; imem_req/imem_addr/imem_ack/imem_rdata instruction
//        port; out_valid/out_ready/out_data display port; halted; illegal_op (sticky).
// Build option: PACESSOR_MUL_EN enables opcode 0a (multiply); otherwise 0a is treated as undefined.
module pacessor_mc #(
   parameter int DATA_W = 8,
   parameter int NREG   = 16,
   parameter int PC_W   = 6
) (
   input  logic              clk,
   input  logic              rst_master_n,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              halted,
   output logic              illegal_op
);
   import pacessor_pkg::*;

   localparam int IDX_W = $clog2(NREG);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              req_q, req_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;

   logic [OP_W-1:0]    f_op;
   logic [FIELD_W-1:0] f_d, f_a, f_b;
   assign {f_op, f_d, f_a, f_b} = ir_q;

   logic [DATA_W-1:0] ra, rb, alu_res;
   logic              alu_we, alu_undef, rf_we;
   logic [31:0]       imm_ext;
   logic [PC_W-1:0]   pc_inc, br_target;

   assign imm_ext   = {24'd0, f_a};
   assign pc_inc    = pc_q + PC_W'(4);
   assign br_target = {f_d[PC_W-1:2], 2'b00};
   assign rf_we     = alu_we && (state_q == ST_EXEC);

   // Only the low index / PC bits of each field are meaningful for a given parameter set.
   logic unused_bits;
   assign unused_bits = ^{f_d, f_b, imm_ext};

   pacessor_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_master_n),
      .ra_idx  (f_a[IDX_W-1:0]),
      .rb_idx  (f_b[IDX_W-1:0]),
      .ra_data (ra),
      .rb_data (rb),
      .we      (rf_we),
      .wd_idx  (f_d[IDX_W-1:0]),
      .wd_data (alu_res)
   );

`ifdef PACESSOR_MUL_EN
   logic [2*DATA_W-1:0] mul_full;
   assign mul_full = {{DATA_W{1'b0}}, ra} * {{DATA_W{1'b0}}, rb};
   logic unused_mul_hi;
   assign unused_mul_hi = ^mul_full[2*DATA_W-1:DATA_W];
`endif

   // Register-writing ALU; shifts by >= DATA_W yield zero by the shift operator's definition.
   always_comb begin
      alu_we    = 1'b0;
      alu_undef = 1'b0;
      alu_res   = '0;
      case (f_op)
         OP_ADD:  begin alu_we = 1'b1; alu_res = ra + rb;  end
         OP_SUB:  begin alu_we = 1'b1; alu_res = ra - rb;  end
         OP_AND:  begin alu_we = 1'b1; alu_res = ra & rb;  end
         OP_OR:   begin alu_we = 1'b1; alu_res = ra | rb;  end
         OP_XOR:  begin alu_we = 1'b1; alu_res = ra ^ rb;  end
         OP_NOT:  begin alu_we = 1'b1; alu_res = ~ra;      end
         OP_SHL:  begin alu_we = 1'b1; alu_res = ra << rb; end
         OP_SHR:  begin alu_we = 1'b1; alu_res = ra >> rb; end
         OP_EQ:   begin alu_we = 1'b1; alu_res = DATA_W'(ra == rb); end
         OP_LOAD: begin alu_we = 1'b1; alu_res = imm_ext[DATA_W-1:0]; end
`ifdef PACESSOR_MUL_EN
         OP_MUL:  begin alu_we = 1'b1; alu_res = mul_full[DATA_W-1:0]; end
`endif
         OP_NOP, OP_DISP, OP_JMP, OP_BEQ, OP_HALT: ;
         default: alu_undef = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      req_d       = req_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      halted_d    = halted_q;
      illegal_d   = illegal_q;
      case (state_q)
         ST_FETCH: begin
            // An ack only counts while our request is actually out.
            if (req_q && imem_ack) begin
               ir_d    = imem_rdata;
               req_d   = 1'b0;
               state_d = ST_EXEC;
            end else begin
               req_d = 1'b1;
            end
         end
         ST_EXEC: begin
            pc_d      = pc_inc;
            illegal_d = illegal_q | alu_undef;
            case (f_op)
               OP_JMP: begin pc_d = br_target; state_d = ST_FETCH; req_d = 1'b1; end
               OP_BEQ: begin
                  if (ra == rb) pc_d = br_target;
                  state_d = ST_FETCH;
                  req_d   = 1'b1;
               end
               OP_DISP: begin out_valid_d = 1'b1; out_data_d = ra; state_d = ST_OUT; end
               OP_HALT: begin halted_d = 1'b1; state_d = ST_HALT; end
               default: begin state_d = ST_FETCH; req_d = 1'b1; end
            endcase
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_FETCH;
               req_d       = 1'b1;
            end
         end
         ST_HALT: ;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_master_n) begin
      if (!rst_master_n) begin
         state_q     <= ST_FETCH;
         pc_q        <= '0;
         ir_q        <= '0;
         req_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         req_q       <= req_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         halted_q    <= halted_d;
         illegal_q   <= illegal_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign halted     = halted_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_pacessor_mc.sv
// tb/tb_pacessor_mc.sv - self-checking bench for pacessor_mc against an instruction-level model
module tb_pacessor_mc;

   localparam int DATA_W = 8;
   localparam int NREG   = 16;
   localparam int PC_W   = 6;

   logic              clk = 1'b0;
   logic              rst_master_n;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              halted;
   logic              illegal_op;

   always #5 clk = ~clk;

   pacessor_mc #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) dut (
      .clk          (clk),
      .rst_master_n (rst_master_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .halted       (halted),
      .illegal_op   (illegal_op)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [16];

   int out_log[$];
   int fetch_log[$];
   int bp_bad, resume_bad, post_halt_req, bp_cycles;
   bit saw_halt;

   int exp_out[$];
   int exp_fetch[$];
   bit exp_illegal, exp_halted;

   // Instruction-level reference: executes the program in mem with plain integer arithmetic.
   task automatic model_run();
      int r[16];
      int pc;
      foreach (r[i]) r[i] = 0;
      pc = 0;
      exp_out.delete();
      exp_fetch.delete();
      exp_illegal = 0;
      exp_halted  = 0;
      for (int step = 0; step < 200 && !exp_halted; step++) begin
         logic [31:0] ins;
         int op, d, a, b, va, vb;
         exp_fetch.push_back(pc);
         ins = mem[pc / 4];
         op = int'(ins[31:24]); d = int'(ins[23:16]); a = int'(ins[15:8]); b = int'(ins[7:0]);
         va = r[a % 16];
         vb = r[b % 16];
         pc = (pc + 4) % 64;
         case (op)
            'h01: r[d % 16] = (va + vb) % 256;
            'h02: r[d % 16] = (va - vb + 256) % 256;
            'h03: r[d % 16] = va & vb;
            'h04: r[d % 16] = va | vb;
            'h05: r[d % 16] = va ^ vb;
            'h06: r[d % 16] = 255 - va;
            'h07: r[d % 16] = (vb >= 8) ? 0 : (va * (1 << vb)) % 256;
            'h08: r[d % 16] = (vb >= 8) ? 0 : va / (1 << vb);
            'h09: r[d % 16] = (va == vb) ? 1 : 0;
            'h10: r[d % 16] = a % 256;
            'h1f: exp_out.push_back(va);
            'h20: pc = d & 'h3c;
            'h21: if (va == vb) pc = d & 'h3c;
            'h00: ;
            'h3f: exp_halted = 1;
            'h0a: begin
`ifdef PACESSOR_MUL_EN
               r[d % 16] = (va * vb) % 256;
`else
               exp_illegal = 1;
`endif
            end
            default: exp_illegal = 1;
         endcase
      end
   endtask

   task automatic do_reset();
      imem_ack     = 1'b0;
      out_ready    = 1'b0;
      rst_master_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_master_n = 1'b1;
   endtask

   // Acts as instruction memory (ack one cycle after req) and output consumer.
   // stop_mode: 0 run to halt, 1 stop on first out_valid, 2 stop on a request for a nonzero address.
   task automatic run_prog(input int max_cyc, input int stall, input bit rnd, input int stop_mode);
      int req_age = 0;
      int stall_left = 0;
      int after_halt = 0;
      bit in_out = 0;
      bit hs_prev = 0;
      logic [DATA_W-1:0] held = '0;
      out_log.delete();
      fetch_log.delete();
      bp_bad = 0; resume_bad = 0; post_halt_req = 0; bp_cycles = 0; saw_halt = 0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         if (hs_prev) begin
            if (out_valid || !imem_req) resume_bad++;
            hs_prev = 0;
         end
         if (stop_mode == 2 && imem_req && imem_addr != '0 && !imem_ack) return;
         if (imem_ack) begin
            imem_ack = 1'b0;
         end else if (imem_req) begin
            if (req_age >= 1) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr[PC_W-1:2]];
               fetch_log.push_back(int'(imem_addr));
               req_age = 0;
            end else begin
               req_age++;
            end
         end else begin
            req_age = 0;
         end
         out_ready = 1'b0;
         if (out_valid) begin
            if (!in_out) begin
               in_out     = 1;
               held       = out_data;
               stall_left = rnd ? int'($urandom_range(0, 3)) : stall;
            end else if (out_data !== held) begin
               bp_bad++;
            end
            if (imem_req) bp_bad++;
            if (stop_mode == 1) return;
            if (stall_left > 0) begin
               stall_left--;
               bp_cycles++;
            end else begin
               out_ready = 1'b1;
               out_log.push_back(int'(out_data));
               in_out  = 0;
               hs_prev = 1;
            end
         end
         if (halted) begin
            saw_halt = 1;
            if (imem_req || out_valid) post_halt_req++;
            after_halt++;
            if (after_halt > 4) break;
         end
      end
      imem_ack  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      imem_ack = 1'b0; out_ready = 1'b0; imem_rdata = '0;
      rst_master_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
      checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%b exp=0", illegal_op); end
      checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
      // Release with a stray ack present: it must be ignored because no request is out yet.
      rst_master_n = 1'b1;
      imem_ack     = 1'b1;
      imem_rdata   = 32'h3f000000;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rel_req_early got=%b exp=0", imem_req); end
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rel_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== '0) begin failures++; $display("FAIL rel_addr got=%0h exp=0", imem_addr); end
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin
         failures++; $display("FAIL stray_ack req=%b halted=%b exp req=1 halted=0", imem_req, halted);
      end
   endtask

   task automatic test_basic();
      mem = '{default: 32'h3f000000};
      mem[0] = 32'h10000500; mem[1] = 32'h10010300; mem[2] = 32'h02020001;
      mem[3] = 32'h1f000200; mem[4] = 32'h3f000000;
      do_reset();
      run_prog(300, 0, 0, 0);
      checks++; if (out_log.size() != 1) begin failures++; $display("FAIL basic_out_count got=%0d exp=1", out_log.size()); end
      checks++; if ((out_log.size() > 0 ? out_log[0] : -1) != 'h02) begin
         failures++; $display("FAIL basic_out_value got=%0h exp=2", (out_log.size() > 0 ? out_log[0] : -1));
      end
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL basic_halted got=%b exp=1", halted); end
      checks++; if (post_halt_req != 0) begin failures++; $display("FAIL basic_post_halt got=%0d exp=0", post_halt_req); end
      checks++; if (fetch_log.size() != 5) begin failures++; $display("FAIL basic_fetches got=%0d exp=5", fetch_log.size()); end
   endtask

   task automatic test_wrap_shift();
      mem = '{default: 32'h3f000000};
      mem[0] = 32'h1000ff00; mem[1] = 32'h10010100; mem[2] = 32'h01020001; mem[3] = 32'h1f000200;
      mem[4] = 32'h10030800; mem[5] = 32'h07050103; mem[6] = 32'h1f000500;
      mem[7] = 32'h10060f00; mem[8] = 32'h06070600; mem[9] = 32'h1f000700; mem[10] = 32'h3f000000;
      model_run();
      do_reset();
      run_prog(400, 0, 0, 0);
      checks++;
      if (out_log.size() != exp_out.size()) begin
         failures++; $display("FAIL wrap_out_count got=%0d exp=%0d", out_log.size(), exp_out.size());
      end else foreach (exp_out[i]) begin
         checks++;
         if (out_log[i] != exp_out[i]) begin
            failures++; $display("FAIL wrap_out[%0d] got=%0h exp=%0h", i, out_log[i], exp_out[i]);
         end
      end
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL wrap_halted got=%b exp=1", halted); end
   endtask

   task automatic test_branch();
      mem = '{default: 32'h3f000000};
      mem[0]  = 32'h10000500; mem[1]  = 32'h10010500; mem[2]  = 32'h20100000;
      mem[4]  = 32'h21200001; mem[8]  = 32'h1f000000; mem[9]  = 32'h10020700;
      mem[10] = 32'h21000002; mem[11] = 32'h1f000200; mem[12] = 32'h3f000000;
      model_run();
      do_reset();
      run_prog(400, 0, 0, 0);
      checks++; if ((fetch_log.size() > 3 ? fetch_log[3] : -1) != 'h10) begin
         failures++; $display("FAIL jmp_target got=%0h exp=10", (fetch_log.size() > 3 ? fetch_log[3] : -1));
      end
      checks++;
      if (fetch_log.size() != exp_fetch.size()) begin
         failures++; $display("FAIL br_fetch_count got=%0d exp=%0d", fetch_log.size(), exp_fetch.size());
      end else foreach (exp_fetch[i]) begin
         checks++;
         if (fetch_log[i] != exp_fetch[i]) begin
            failures++; $display("FAIL br_fetch[%0d] got=%0h exp=%0h", i, fetch_log[i], exp_fetch[i]);
         end
      end
      checks++;
      if (out_log.size() != exp_out.size()) begin
         failures++; $display("FAIL br_out_count got=%0d exp=%0d", out_log.size(), exp_out.size());
      end else foreach (exp_out[i]) begin
         checks++;
         if (out_log[i] != exp_out[i]) begin
            failures++; $display("FAIL br_out[%0d] got=%0h exp=%0h", i, out_log[i], exp_out[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      mem = '{default: 32'h3f000000};
      mem[0] = 32'h10004200; mem[1] = 32'h1f000000; mem[2] = 32'h10010900;
      mem[3] = 32'h1f000100; mem[4] = 32'h3f000000;
      model_run();
      do_reset();
      run_prog(400, 5, 0, 0);
      checks++; if (bp_bad != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", bp_bad); end
      checks++; if (resume_bad != 0) begin failures++; $display("FAIL bp_resume got=%0d exp=0", resume_bad); end
      checks++; if (bp_cycles != 10) begin failures++; $display("FAIL bp_held_cycles got=%0d exp=10", bp_cycles); end
      checks++;
      if (out_log.size() != exp_out.size()) begin
         failures++; $display("FAIL bp_out_count got=%0d exp=%0d", out_log.size(), exp_out.size());
      end else foreach (exp_out[i]) begin
         checks++;
         if (out_log[i] != exp_out[i]) begin
            failures++; $display("FAIL bp_out[%0d] got=%0h exp=%0h", i, out_log[i], exp_out[i]);
         end
      end
   endtask

   task automatic test_random();
      int ops[17] = '{'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09,
                      'h10, 'h10, 'h1f, 'h1f, 'h00, 'h0a, 'h0b, 'h22};
      for (int it = 0; it < 4; it++) begin
         mem = '{default: 32'h3f000000};
         for (int i = 0; i < 15; i++) begin
            int op;
            op = (i < 3) ? 'h10 : ops[$urandom_range(0, 16)];
            mem[i] = {op[7:0], 8'($urandom), 8'($urandom), 8'($urandom)};
         end
         model_run();
         do_reset();
         run_prog(1000, 0, 1, 0);
         checks++;
         if (out_log.size() != exp_out.size()) begin
            failures++; $display("FAIL rnd%0d_out_count got=%0d exp=%0d", it, out_log.size(), exp_out.size());
         end else foreach (exp_out[i]) begin
            checks++;
            if (out_log[i] != exp_out[i]) begin
               failures++; $display("FAIL rnd%0d_out[%0d] got=%0h exp=%0h", it, i, out_log[i], exp_out[i]);
            end
         end
         checks++; if (illegal_op !== exp_illegal) begin
            failures++; $display("FAIL rnd%0d_illegal got=%b exp=%b", it, illegal_op, exp_illegal);
         end
         checks++; if (halted !== exp_halted) begin
            failures++; $display("FAIL rnd%0d_halted got=%b exp=%b", it, halted, exp_halted);
         end
         checks++; if (fetch_log.size() != exp_fetch.size()) begin
            failures++; $display("FAIL rnd%0d_fetches got=%0d exp=%0d", it, fetch_log.size(), exp_fetch.size());
         end
         checks++; if (bp_bad != 0 || resume_bad != 0) begin
            failures++; $display("FAIL rnd%0d_handshake got=%0d/%0d exp=0/0", it, bp_bad, resume_bad);
         end
      end
   endtask

   task automatic test_illegal_cfg();
      int exp_val;
      bit exp_ill;
`ifdef PACESSOR_MUL_EN
      exp_val = 'h0c; exp_ill = 0;
`else
      exp_val = 'h00; exp_ill = 1;
`endif
      mem = '{default: 32'h3f000000};
      mem[0] = 32'h10000300; mem[1] = 32'h10010400; mem[2] = 32'h0a020001;
      mem[3] = 32'h1f000200; mem[4] = 32'h3f000000;
      do_reset();
      run_prog(300, 0, 0, 0);
      checks++; if ((out_log.size() > 0 ? out_log[0] : -1) != exp_val) begin
         failures++; $display("FAIL op0a_result got=%0h exp=%0h", (out_log.size() > 0 ? out_log[0] : -1), exp_val);
      end
      checks++; if (illegal_op !== exp_ill) begin
         failures++; $display("FAIL op0a_illegal got=%b exp=%b", illegal_op, exp_ill);
      end
   endtask

   task automatic test_reset_mid();
      mem = '{default: 32'h3f000000};
      mem[0] = 32'h0b000000; mem[1] = 32'h10005a00; mem[2] = 32'h1f000000; mem[3] = 32'h3f000000;
      do_reset();
      run_prog(100, 0, 0, 1);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h5a || illegal_op !== 1'b1) begin
         failures++; $display("FAIL mid_out_pre valid=%b data=%0h ill=%b exp 1/5a/1", out_valid, out_data, illegal_op);
      end
      #2 rst_master_n = 1'b0;
      imem_ack = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== '0 || illegal_op !== 1'b0 || imem_req !== 1'b0) begin
         failures++; $display("FAIL mid_out_reset valid=%b data=%0h ill=%b req=%b exp 0/0/0/0",
                              out_valid, out_data, illegal_op, imem_req);
      end
      mem[0] = 32'h10000100; mem[1] = 32'h00000000; mem[2] = 32'h00000000;
      do_reset();
      run_prog(100, 0, 0, 2);
      checks++; if (imem_req !== 1'b1 || imem_addr == '0) begin
         failures++; $display("FAIL mid_fetch_pre req=%b addr=%0h exp req=1 addr!=0", imem_req, imem_addr);
      end
      #2 rst_master_n = 1'b0;
      imem_ack = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== '0 || halted !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL mid_fetch_reset req=%b addr=%0h halted=%b valid=%b exp all 0",
                              imem_req, imem_addr, halted, out_valid);
      end
      @(negedge clk);
      rst_master_n = 1'b1;
   endtask

   initial begin
      rst_master_n = 1'b0;
      imem_ack     = 1'b0;
      imem_rdata   = '0;
      out_ready    = 1'b0;
      test_reset();
      test_basic();
      test_wrap_shift();
      test_branch();
      test_backpressure();
      test_random();
      test_illegal_cfg();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
